// File: rtl/wb_regfile_pkg.sv
// Shared definitions for the write-back register file slice: default widths,
// the zero word, the NOP register address and write-enable levels.
package wb_regfile_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int NOP_REG_ADDR = 0;

  localparam logic [DATA_W_DEF-1:0] ZERO_WORD = '0;

  typedef enum logic {
    WRITE_DISABLE = 1'b0,
    WRITE_ENABLE  = 1'b1
  } wr_en_e;

endpackage

// File: rtl/wb_hilo_reg.sv
// HI/LO special-register pair with write-through bypass and async reset.
module wb_hilo_reg
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wb_hi,
  input  logic [DATA_W-1:0] wb_lo,
  input  logic              wb_whilo,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam logic [DATA_W-1:0] ZERO = DATA_W'(ZERO_WORD);

  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= ZERO;
      lo <= ZERO;
    end else if (wb_whilo == WRITE_ENABLE) begin
      hi <= wb_hi;
      lo <= wb_lo;
    end
  end

  // Bypass is suppressed while reset is held so readers never see stale data.
  always_comb begin
    hi_o = hi;
    lo_o = lo;
    if (rst) begin
      hi_o = ZERO;
      lo_o = ZERO;
    end else if (wb_whilo == WRITE_ENABLE) begin
      hi_o = wb_hi;
      lo_o = wb_lo;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage GPR file with two bypassed read ports, HI/LO pair and a
// retired-write counter.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic [ADDR_W-1:0] wb_wd,
  input  logic              wb_wreg,
  input  logic [DATA_W-1:0] wb_hi,
  input  logic [DATA_W-1:0] wb_lo,
  input  logic              wb_whilo,
  input  logic              re1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic [31:0]       wr_count
);

  localparam int unsigned       NUM_REGS = 2 ** ADDR_W;
  localparam logic [DATA_W-1:0] ZERO     = DATA_W'(ZERO_WORD);
  localparam logic [ADDR_W-1:0] NOP_ADDR = ADDR_W'(NOP_REG_ADDR);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [31:0]       wr_cnt;
  logic              gpr_we;
  logic              hilo_we;

  assign gpr_we   = (wb_wreg == WRITE_ENABLE) && (wb_wd != NOP_ADDR);
  assign hilo_we  = (wb_whilo == WRITE_ENABLE);
  assign wr_count = wr_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= ZERO;
      end
    end else if (gpr_we) begin
      regs[wb_wd] <= wb_wdata;
    end
  end

  // A cycle with both write kinds retires as one architectural write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt <= '0;
    end else if (gpr_we || hilo_we) begin
      wr_cnt <= wr_cnt + 32'd1;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic re,
                                                  input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = regs[addr];
    if (rst || re != WRITE_ENABLE || addr == NOP_ADDR) begin
      val = ZERO;
    end else if (wb_wreg == WRITE_ENABLE && wb_wd == addr) begin
      val = wb_wdata;
    end
    return val;
  endfunction

  always_comb begin
    rdata1 = read_port(re1, raddr1);
    rdata2 = read_port(re2, raddr2);
  end

  wb_hilo_reg #(
    .DATA_W (DATA_W)
  ) u_hilo (
    .clk      (clk),
    .rst      (rst),
    .wb_hi    (wb_hi),
    .wb_lo    (wb_lo),
    .wb_whilo (wb_whilo),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized
// traffic compared every cycle against an array-based reference model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] wb_wdata = '0;
  logic [4:0]  wb_wd = '0;
  logic        wb_wreg = 1'b0;
  logic [31:0] wb_hi = '0;
  logic [31:0] wb_lo = '0;
  logic        wb_whilo = 1'b0;
  logic        re1 = 1'b0;
  logic        re2 = 1'b0;
  logic [4:0]  raddr1 = '0;
  logic [4:0]  raddr2 = '0;
  logic [31:0] rdata1, rdata2, hi_o, lo_o, wr_count;

  wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .wb_wdata(wb_wdata), .wb_wd(wb_wd), .wb_wreg(wb_wreg),
    .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo), .re1(re1), .re2(re2),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .hi_o(hi_o), .lo_o(lo_o), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_regs [32];
  logic [31:0] m_hi, m_lo, m_cnt;
  logic [31:0] cnt_bias = '0;  // offset applied when the DUT counter is preset
  logic        chk_en = 1'b0;
  int          n_pass = 0;
  int          n_total = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_hi  = '0;
      m_lo  = '0;
      m_cnt = '0;
    end else begin
      if (wb_wreg && wb_wd != 0) m_regs[wb_wd] = wb_wdata;
      if (wb_whilo) begin
        m_hi = wb_hi;
        m_lo = wb_lo;
      end
      if ((wb_wreg && wb_wd != 0) || wb_whilo) m_cnt = m_cnt + 1;
    end
  end

  function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] a);
    if (rst || !re || a == 0) return 32'h0;
    if (wb_wreg && wb_wd == a) return wb_wdata;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] exp_hi();
    if (rst) return 32'h0;
    return wb_whilo ? wb_hi : m_hi;
  endfunction

  function automatic logic [31:0] exp_lo();
    if (rst) return 32'h0;
    return wb_whilo ? wb_lo : m_lo;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("rdata1", rdata1, exp_rd(re1, raddr1));
      check("rdata2", rdata2, exp_rd(re2, raddr2));
      check("hi_o", hi_o, exp_hi());
      check("lo_o", lo_o, exp_lo());
      check("wr_count", wr_count, m_cnt + cnt_bias);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_wreg = 0; wb_wd = 0; wb_wdata = 0; wb_whilo = 0; wb_hi = 0; wb_lo = 0;
    re1 = 0; re2 = 0; raddr1 = 0; raddr2 = 0;
  endtask

  initial begin
    // Reset state with write attempts and bypass requests that must be ignored
    re1 = 1; raddr1 = 5; wb_wreg = 1; wb_wd = 5; wb_wdata = 32'h5555_5555;
    wb_whilo = 1; wb_hi = 32'h5; wb_lo = 32'h6;
    chk_en = 1;
    @(negedge clk);
    check("reset_rdata1", rdata1, 32'h0);
    check("reset_hi_o", hi_o, 32'h0);
    check("reset_wr_count", wr_count, 32'h0);
    next_cycle();
    rst = 0;
    idle();

    // Write reg5, read it back next cycle
    wb_wreg = 1; wb_wd = 5; wb_wdata = 32'h1234_5678;
    next_cycle();
    idle(); re1 = 1; raddr1 = 5;
    @(negedge clk);
    check("reg5_read", rdata1, 32'h1234_5678);

    // Same-cycle bypass on port 2, then the stored value
    next_cycle();
    idle(); wb_wreg = 1; wb_wd = 7; wb_wdata = 32'hCAFE_F00D; re2 = 1; raddr2 = 7;
    @(negedge clk);
    check("bypass_rdata2", rdata2, 32'hCAFE_F00D);
    next_cycle();
    wb_wreg = 0; wb_wdata = 0;
    @(negedge clk);
    check("stored_rdata2", rdata2, 32'hCAFE_F00D);

    // Writes to reg0 are dropped and not counted
    next_cycle();
    idle(); wb_wreg = 1; wb_wd = 0; wb_wdata = 32'hFFFF_FFFF; re1 = 1; raddr1 = 0;
    @(negedge clk);
    check("reg0_bypass", rdata1, 32'h0);
    next_cycle();
    idle(); re1 = 1; raddr1 = 0; re2 = 1; raddr2 = 0;
    @(negedge clk);
    check("reg0_read", rdata1, 32'h0);
    check("wr_count_reg0", wr_count, 32'd2);

    // Fresh reset, then disabled read port hides reg3
    next_cycle();
    rst = 1; cnt_bias = 0; idle();
    next_cycle();
    rst = 0;
    wb_wreg = 1; wb_wd = 3; wb_wdata = 32'h1234;
    next_cycle();
    idle(); re1 = 0; raddr1 = 3; re2 = 1; raddr2 = 3;
    @(negedge clk);
    check("re1_off", rdata1, 32'h0);
    check("reg3_port2", rdata2, 32'h1234);
    check("wr_count_one", wr_count, 32'd1);

    // HI/LO plus GPR write in one cycle counts once
    next_cycle();
    idle(); wb_whilo = 1; wb_hi = 32'hA; wb_lo = 32'hB; wb_wreg = 1; wb_wd = 9; wb_wdata = 32'h99;
    @(negedge clk);
    check("hi_bypass", hi_o, 32'hA);
    check("lo_bypass", lo_o, 32'hB);
    next_cycle();
    idle(); re1 = 1; raddr1 = 9;
    @(negedge clk);
    check("wr_count_dual", wr_count, 32'd2);
    check("hi_stored", hi_o, 32'hA);
    check("lo_stored", lo_o, 32'hB);
    check("reg9_dual", rdata1, 32'h99);

    // Counter wrap from all-ones
    next_cycle();
    force dut.wr_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.wr_cnt;
    cnt_bias = 32'hFFFF_FFFF - m_cnt;
    wb_wreg = 1; wb_wd = 4; wb_wdata = 32'h44;
    next_cycle();
    idle();
    @(negedge clk);
    check("wr_count_wrap", wr_count, 32'h0);

    // Mid-cycle reset clears everything without a clock edge
    next_cycle();
    re1 = 1; raddr1 = 3; re2 = 1; raddr2 = 9;
    #2;
    rst = 1; cnt_bias = 0;
    #1;
    check("async_rdata1", rdata1, 32'h0);
    check("async_rdata2", rdata2, 32'h0);
    check("async_hi_o", hi_o, 32'h0);
    check("async_wr_count", wr_count, 32'h0);
    next_cycle();
    rst = 0;

    // Randomized traffic with occasional resets
    for (int c = 0; c < 800; c++) begin
      wb_wreg  = ($urandom_range(0, 3) != 0);
      wb_wd    = 5'($urandom_range(0, 7));
      wb_wdata = $urandom;
      wb_whilo = ($urandom_range(0, 3) == 0);
      wb_hi    = $urandom;
      wb_lo    = $urandom;
      re1      = ($urandom_range(0, 4) != 0);
      re2      = ($urandom_range(0, 4) != 0);
      raddr1   = 5'($urandom_range(0, 7));
      raddr2   = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 7));
      if (rst) rst = 0;
      else if ($urandom_range(0, 59) == 0) begin
        rst = 1;
        cnt_bias = 0;
      end
      next_cycle();
    end

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter DATA_W, default 32: width of every data word (GPR, HI, LO).
REQ-002 Parameter ADDR_W, default 5: GPR address width; 2**ADDR_W registers.
REQ-003 Port clk, input, 1: single clock; all state updates on posedge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port wb_wdata, input, DATA_W: GPR write data from the MEM/WB stage register.
REQ-006 Port wb_wd, input, ADDR_W: GPR write address.
REQ-007 Port wb_wreg, input, 1: GPR write enable.
REQ-008 Port wb_hi, input, DATA_W: HI write data.
REQ-009 Port wb_lo, input, DATA_W: LO write data.
REQ-010 Port wb_whilo, input, 1: HI/LO write enable; writes both together.
REQ-011 Ports re1 and re2, input, 1 each: read enables for ports 1 and 2.
REQ-012 Ports raddr1 and raddr2, input, ADDR_W each: read addresses.
REQ-013 Ports rdata1 and rdata2, output, DATA_W each: combinational read data.
REQ-014 Ports hi_o and lo_o, output, DATA_W each: current HI and LO values, bypassed.
REQ-015 Port wr_count, output, 32: count of retired architectural writes.

Function
REQ-016 GPR write: at posedge, if wb_wreg=1 and wb_wd!=0, the block SHALL store wb_wdata into reg[wb_wd].
REQ-017 Register 0 SHALL never be written; a write to address 0 SHALL be silently dropped.
REQ-018 Read port n SHALL output zero when re_n=0 or raddr_n=0.
REQ-019 Otherwise, if wb_wreg=1 and wb_wd=raddr_n, read port n SHALL output wb_wdata in the same cycle (write-through bypass, zero latency).
REQ-020 Otherwise, read port n SHALL output reg[raddr_n].
REQ-021 Both read ports SHALL be independent; identical addresses SHALL return identical data.
REQ-022 HI/LO write: at posedge, if wb_whilo=1, the block SHALL load hi<=wb_hi and lo<=wb_lo.
REQ-023 hi_o and lo_o SHALL equal wb_hi and wb_lo while wb_whilo=1, and the stored hi and lo otherwise.
REQ-024 wr_count SHALL increment by 1 at each posedge where (wb_wreg=1 and wb_wd!=0) or wb_whilo=1.
REQ-025 wr_count SHALL increment by exactly 1 when both write kinds occur in the same cycle.
REQ-026 wr_count SHALL wrap from 0xFFFFFFFF to 0.
REQ-027 A bubble (wb_wreg=0, wb_wd=0, wb_whilo=0) SHALL change no state and no count.
REQ-028 A GPR write and a HI/LO write in the same cycle SHALL both take effect.

Reset
REQ-029 On rst=1, asynchronously: all GPRs=0, hi=0, lo=0, wr_count=0.
REQ-030 During reset, rdata1/rdata2 SHALL read 0 and bypass SHALL be suppressed.
REQ-031 During reset, hi_o/lo_o SHALL read 0 and bypass SHALL be suppressed.
REQ-032 A write coinciding with reset assertion SHALL be lost.
REQ-033 The first posedge after rst deasserts SHALL perform normal writes.

Structure
REQ-034 Data width, address width, the zero word, the NOP register address and write enable/disable levels SHALL come from the shared define package.
REQ-035 The HI/LO pair, its bypass and its reset SHALL be one sub-module, wb_hilo_reg; the GPR array and the counter SHALL stay in wb_regfile.

Verification
REQ-036 Reset, then write reg5=0x12345678; next cycle read raddr1=5, re1=1 -> rdata1=0x12345678.
REQ-037 wb_wreg=1, wb_wd=7, wb_wdata=0xCAFEF00D with raddr2=7 in the same cycle -> rdata2=0xCAFEF00D combinationally; stored value follows next cycle.
REQ-038 Write 0xFFFFFFFF to reg0, then read raddr1=0 -> 0.
REQ-039 Write 0x1234 to reg3, then read raddr1=3 with re1=0 -> 0; wr_count=1.
REQ-040 wb_whilo=1 with hi=0xA, lo=0xB and a GPR write in the same cycle -> hi_o=0xA and lo_o=0xB immediately; wr_count +1 only.
REQ-041 Force wr_count to 0xFFFFFFFF, then one write -> wr_count=0.
REQ-042 Assert rst mid-stream -> all reads 0 immediately and wr_count=0 without waiting for a clock edge.
